timer_counter: RTL and testbench
================================

// Module: timer_counter
// PURPOSE
//   Memory-mapped programmable down-counter that feeds the CPU interrupt path.
//   Sits on the system bridge as a slave peripheral. Software programs it with
//   word writes and reads it back the same way. Its irq output drives one bit of
//   the 6-bit hardware-interrupt vector consumed by the CP0 exception unit.
//   Supports one-shot (level IRQ) and auto-reload (1-cycle IRQ pulse) modes.
// PARAMETERS
//   PRESET_RESET   32'h0   reset value of the PRESET register
// PORTS
//   clk     in   1    clock; all state changes on rising edge
//   reset   in   1    synchronous, active-high
//   addr    in   2    word offset: 0=CTRL, 1=PRESET, 2=COUNT, 3=reserved
//   we      in   1    bus write strobe, sampled at rising edge
//   wdata   in   32   bus write data
//   rdata   out  32   bus read data, combinational from addr
//   irq     out  1    interrupt request to the CP0 HWInt vector
// BEHAVIOUR
//   CTRL[0] = EN. CTRL[2:1] = MODE (00 one-shot, 01 auto-reload, 1x acts as one-shot).
//     CTRL[3] = IM (irq mask). CTRL[31:4] read 0 and ignore writes.
//   Read map: 0 -> {28'b0,CTRL[3:0]}; 1 -> PRESET; 2 -> COUNT; 3 -> 32'h0.
//   COUNT is read-only; writes to addr 2 or 3 are ignored.
//   Reset: state=IDLE, CTRL=0, PRESET=PRESET_RESET, COUNT=0, irq_flag=0, irq=0.
//     Reset mid-count aborts everything in the same edge.
//   irq = irq_flag & CTRL[3]. Registered, no combinational path from bus to irq.
//   FSM, one transition per edge:
//     IDLE: EN=1 -> LOAD; else stay.
//     LOAD: COUNT<=PRESET -> CNT.
//     CNT:  EN=0 -> IDLE, COUNT holds.
//           else COUNT>1 -> COUNT<=COUNT-1, stay.
//           else (COUNT<=1) -> COUNT<=0, irq_flag<=1, go to INT.
//     INT:  one-shot: EN<=0, go to IDLE, irq_flag stays set.
//           auto-reload: irq_flag<=0, go to IDLE; EN stays 1, so reload follows.
//   One-shot irq_flag is cleared only by a bus write to CTRL or PRESET, or by reset.
//   Latency: the enabling CTRL write at edge E0 gives COUNT=PRESET after E2 and
//     irq high after E(PRESET+2) for PRESET>=1. PRESET=0 behaves as PRESET=1.
//   Auto-reload period is PRESET+3 cycles. The irq pulse is exactly 1 cycle wide.
//   Disabling mid-count then re-enabling reloads from PRESET; it never resumes.
//   A PRESET write during CNT does not change COUNT; it takes effect at next LOAD.
//   Same-edge conflict: a bus CTRL write wins over the FSM's EN clear in INT.
//     The FSM state update still occurs.
//   Writing IM=0 masks irq but keeps irq_flag. Setting IM=1 later re-exposes it.
//     A CTRL write in one-shot mode clears the flag, so an IM-only update drops it.
// TESTING
//   1) PRESET=3, CTRL=0x9 at E0 -> COUNT 3,2,1,0 after E2..E5.
//      irq=1 from E5, CTRL reads 0x8 after E6, irq still 1 at E20.
//   2) Continue 1: write CTRL=0x0 -> irq=0 the cycle after the write edge.
//   3) PRESET=2, CTRL=0xB (auto-reload) -> 1-cycle irq pulses every 5 cycles.
//      EN stays 1, and COUNT reloads to 2 two edges after each pulse.
//   4) PRESET=10, enable, write CTRL=0x8 when COUNT=6 -> IDLE, COUNT holds 6, no irq.
//      Re-enable -> COUNT=10 after 2 edges.
//   5) PRESET=0 one-shot -> irq after E3. CTRL=0x1 (IM=0) -> irq stays 0, flag set.
//      Read CTRL and COUNT=0 to confirm.
//   6) Assert reset during CNT with irq pending -> all regs at reset values and irq=0
//      the next cycle. rdata at addr 1 = PRESET_RESET.

Source files
------------

// File: rtl/timer_counter.sv
// Memory-mapped programmable down-counter with interrupt output.
// Word-addressed slave: CTRL (EN, MODE, IM), PRESET, read-only COUNT.
// One-shot mode raises a level irq that holds until software writes CTRL or
// PRESET; auto-reload mode produces a single-cycle pulse and restarts.
//
//   state  | meaning
//   -------+---------------------------------------------------
//   IDLE   | waiting for EN
//   LOAD   | copy PRESET into COUNT
//   CNT    | decrement COUNT while EN stays set
//   INT    | terminal count reached; finish one-shot or reload
module timer_counter #(
  parameter logic [31:0] PRESET_RESET = 32'h0
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [1:0]  addr,
  input  logic        we,
  input  logic [31:0] wdata,
  output logic [31:0] rdata,
  output logic        irq
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_LOAD = 2'd1,
    S_CNT  = 2'd2,
    S_INT  = 2'd3
  } state_t;

  state_t      r_state;
  state_t      w_state_next;
  logic [3:0]  r_ctrl;
  logic [31:0] r_preset;
  logic [31:0] r_count;
  logic [31:0] w_count_next;
  logic        r_irq_flag;
  logic        w_flag_set;
  logic        w_flag_clr_fsm;
  logic        w_en_clr;
  logic        w_wr_ctrl;
  logic        w_wr_preset;
  logic        w_en;
  logic        w_auto;
  logic        w_unused_wdata;

  assign w_wr_ctrl      = we && (addr == 2'd0);
  assign w_wr_preset    = we && (addr == 2'd1);
  assign w_en           = r_ctrl[0];
  // MODE 1x behaves as one-shot, so only the exact 01 encoding reloads.
  assign w_auto         = (r_ctrl[2:1] == 2'b01);
  assign w_unused_wdata = ^wdata[31:4];

  // Next-state, next-count and flag/EN side effects of the sequencer.
  always_comb begin
    w_state_next   = r_state;
    w_count_next   = r_count;
    w_flag_set     = 1'b0;
    w_flag_clr_fsm = 1'b0;
    w_en_clr       = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (w_en) w_state_next = S_LOAD;
      end
      S_LOAD: begin
        w_count_next = r_preset;
        w_state_next = S_CNT;
      end
      S_CNT: begin
        if (!w_en) begin
          w_state_next = S_IDLE;
        end else if (r_count > 32'd1) begin
          w_count_next = r_count - 32'd1;
        end else begin
          // COUNT of 0 (PRESET=0) terminates exactly like COUNT of 1.
          w_count_next = 32'd0;
          w_flag_set   = 1'b1;
          w_state_next = S_INT;
        end
      end
      S_INT: begin
        if (w_auto) w_flag_clr_fsm = 1'b1;
        else        w_en_clr       = 1'b1;
        w_state_next = S_IDLE;
      end
      default: w_state_next = S_IDLE;
    endcase
  end

  // State register.
  always_ff @(posedge clk) begin
    if (reset) r_state <= S_IDLE;
    else       r_state <= w_state_next;
  end

  // CTRL register; a bus write takes priority over the one-shot EN clear.
  always_ff @(posedge clk) begin
    if (reset)          r_ctrl    <= 4'h0;
    else if (w_wr_ctrl) r_ctrl    <= wdata[3:0];
    else if (w_en_clr)  r_ctrl[0] <= 1'b0;
  end

  // PRESET register; only consumed in LOAD, so mid-count writes wait.
  always_ff @(posedge clk) begin
    if (reset)            r_preset <= PRESET_RESET;
    else if (w_wr_preset) r_preset <= wdata;
  end

  // COUNT register, owned entirely by the sequencer.
  always_ff @(posedge clk) begin
    if (reset) r_count <= 32'd0;
    else       r_count <= w_count_next;
  end

  // Interrupt flag; a terminal count is never lost to a same-edge bus clear.
  always_ff @(posedge clk) begin
    if (reset)                                          r_irq_flag <= 1'b0;
    else if (w_flag_set)                                r_irq_flag <= 1'b1;
    else if (w_wr_ctrl || w_wr_preset || w_flag_clr_fsm) r_irq_flag <= 1'b0;
  end

  // irq is a function of two flops only, so no bus path reaches it.
  assign irq = r_irq_flag & r_ctrl[3];

  // Combinational read mux.
  always_comb begin
    rdata = 32'h0;
    case (addr)
      2'd0:    rdata = {28'h0, r_ctrl};
      2'd1:    rdata = r_preset;
      2'd2:    rdata = r_count;
      default: rdata = 32'h0;
    endcase
  end

endmodule

// File: tb/tb_timer_counter.sv
// Directed bench for timer_counter: a vector table for the one-shot basic
// sequence and read map, then hand-written multi-cycle sequences.
module tb_timer_counter;

  localparam logic [31:0] PR = 32'h0000_1234;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic [1:0]  addr = 2'd0;
  logic        we = 1'b0;
  logic [31:0] wdata = 32'h0;
  logic [31:0] rdata;
  logic        irq;

  int n_checks = 0;
  int n_fail   = 0;

  timer_counter #(.PRESET_RESET(PR)) dut (
    .clk   (clk),
    .reset (reset),
    .addr  (addr),
    .we    (we),
    .wdata (wdata),
    .rdata (rdata),
    .irq   (irq)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic        we;
    logic [1:0]  waddr;
    logic [31:0] wdata;
    int          nidle;
    logic [1:0]  raddr;
    logic [31:0] exp_rdata;
    logic        exp_irq;
  } vec_t;

  vec_t tbl[13];

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic wr(input logic [1:0] a, input logic [31:0] d);
    we = 1'b1; addr = a; wdata = d;
    tick();
    we = 1'b0;
  endtask

  task automatic do_reset();
    reset = 1'b1;
    tick();
    reset = 1'b0;
  endtask

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", nm, act, exp);
    end
  endtask

  task automatic rd_chk(input string nm, input logic [1:0] a, input logic [31:0] exp);
    addr = a;
    #1;
    chk(nm, rdata, exp);
  endtask

  task automatic irq_chk(input string nm, input logic exp);
    #1;
    chk(nm, {31'h0, irq}, {31'h0, exp});
  endtask

  initial begin
    // One-shot PRESET=3, CTRL=0x9 written at E0; each row notes the edge reached.
    tbl[0]  = '{1'b1, 2'd1, 32'd3,          0,  2'd1, 32'd3, 1'b0}; // PRESET write
    tbl[1]  = '{1'b1, 2'd0, 32'h9,          0,  2'd0, 32'h9, 1'b0}; // E0
    tbl[2]  = '{1'b0, 2'd0, 32'h0,          1,  2'd2, 32'd0, 1'b0}; // E1 LOAD
    tbl[3]  = '{1'b0, 2'd0, 32'h0,          1,  2'd2, 32'd3, 1'b0}; // E2
    tbl[4]  = '{1'b0, 2'd0, 32'h0,          1,  2'd2, 32'd2, 1'b0}; // E3
    tbl[5]  = '{1'b0, 2'd0, 32'h0,          1,  2'd2, 32'd1, 1'b0}; // E4
    tbl[6]  = '{1'b0, 2'd0, 32'h0,          1,  2'd2, 32'd0, 1'b1}; // E5 irq
    tbl[7]  = '{1'b0, 2'd0, 32'h0,          1,  2'd0, 32'h8, 1'b1}; // E6 EN cleared
    tbl[8]  = '{1'b0, 2'd0, 32'h0,          14, 2'd2, 32'd0, 1'b1}; // E20 irq held
    tbl[9]  = '{1'b1, 2'd2, 32'h55,         0,  2'd2, 32'd0, 1'b1}; // COUNT read-only
    tbl[10] = '{1'b1, 2'd3, 32'hAA,         0,  2'd3, 32'h0, 1'b1}; // reserved
    tbl[11] = '{1'b1, 2'd0, 32'h0,          0,  2'd0, 32'h0, 1'b0}; // CTRL=0 clears irq
    tbl[12] = '{1'b1, 2'd0, 32'hFFFF_FFF0,  0,  2'd0, 32'h0, 1'b0}; // upper bits ignored

    // Reset state
    do_reset();
    rd_chk("rst_ctrl",   2'd0, 32'h0);
    rd_chk("rst_preset", 2'd1, PR);
    rd_chk("rst_count",  2'd2, 32'h0);
    irq_chk("rst_irq", 1'b0);

    // Table-driven one-shot sequence
    for (int i = 0; i < 13; i++) begin
      if (tbl[i].we) wr(tbl[i].waddr, tbl[i].wdata);
      for (int j = 0; j < tbl[i].nidle; j++) tick();
      rd_chk($sformatf("vec%0d_rdata", i), tbl[i].raddr, tbl[i].exp_rdata);
      irq_chk($sformatf("vec%0d_irq", i), tbl[i].exp_irq);
    end

    // Auto-reload PRESET=2: COUNT 2,1,0,0,0 repeating from E2, irq at phase 2
    do_reset();
    wr(2'd1, 32'd2);
    wr(2'd0, 32'hB);
    addr = 2'd2;
    for (int k = 1; k <= 20; k++) begin
      int p;
      logic [31:0] exp_cnt;
      logic exp_irq;
      tick();
      p = (k - 2) % 5;
      exp_cnt = (k < 2) ? 32'd0 : (p == 0) ? 32'd2 : (p == 1) ? 32'd1 : 32'd0;
      exp_irq = (k >= 2) && (p == 2);
      rd_chk($sformatf("auto_cnt_E%0d", k), 2'd2, exp_cnt);
      irq_chk($sformatf("auto_irq_E%0d", k), exp_irq);
    end
    rd_chk("auto_ctrl", 2'd0, 32'hB);

    // Disable mid-count: PRESET=10, disable on the edge where COUNT becomes 6
    do_reset();
    wr(2'd1, 32'd10);
    wr(2'd0, 32'h9);                      // E0
    for (int k = 1; k <= 5; k++) tick();  // after E5 COUNT=7
    rd_chk("dis_cnt_E5", 2'd2, 32'd7);
    wr(2'd0, 32'h8);                      // E6: EN still 1 this edge -> 6
    rd_chk("dis_cnt_E6", 2'd2, 32'd6);
    for (int k = 0; k < 5; k++) tick();
    rd_chk("dis_cnt_hold", 2'd2, 32'd6);
    irq_chk("dis_irq", 1'b0);
    wr(2'd0, 32'h9);                      // F0
    tick();                               // F1
    rd_chk("reen_cnt_F1", 2'd2, 32'd6);
    tick();                               // F2
    rd_chk("reen_cnt_F2", 2'd2, 32'd10);
    wr(2'd1, 32'd20);                     // PRESET write during CNT
    rd_chk("preset_mid_cnt", 2'd2, 32'd9);
    rd_chk("preset_mid_rd",  2'd1, 32'd20);

    // PRESET=0 one-shot: irq after E3
    do_reset();
    wr(2'd1, 32'd0);
    wr(2'd0, 32'h9);                      // E0
    tick(); tick();                       // E2
    irq_chk("p0_irq_E2", 1'b0);
    tick();                               // E3
    irq_chk("p0_irq_E3", 1'b1);
    rd_chk("p0_cnt", 2'd2, 32'd0);

    // Reset while irq pending
    do_reset();
    irq_chk("rst_pend_irq", 1'b0);
    rd_chk("rst_pend_preset", 2'd1, PR);

    // PRESET=0 with IM=0: irq never rises, EN clears, COUNT=0
    wr(2'd1, 32'd0);
    wr(2'd0, 32'h1);
    for (int k = 1; k <= 6; k++) begin
      tick();
      irq_chk($sformatf("mask_irq_E%0d", k), 1'b0);
    end
    rd_chk("mask_ctrl", 2'd0, 32'h0);
    rd_chk("mask_cnt",  2'd2, 32'd0);

    // CTRL write in INT beats the one-shot EN clear
    do_reset();
    wr(2'd1, 32'd1);
    wr(2'd0, 32'h9);                      // E0
    tick(); tick(); tick();               // E3 -> INT
    irq_chk("int_irq_E3", 1'b1);
    wr(2'd0, 32'h9);                      // E4 in INT
    rd_chk("int_ctrl_E4", 2'd0, 32'h9);
    irq_chk("int_irq_E4", 1'b0);
    tick(); tick();                       // E6
    rd_chk("int_cnt_E6", 2'd2, 32'd1);
    irq_chk("int_irq_E6", 1'b0);
    tick();                               // E7
    irq_chk("int_irq_E7", 1'b1);
    tick();                               // E8
    rd_chk("int_ctrl_E8", 2'd0, 32'h8);

    // Reset mid-count
    do_reset();
    wr(2'd1, 32'd100);
    wr(2'd0, 32'hB);
    for (int k = 0; k < 10; k++) tick();
    rd_chk("pre_rst_cnt", 2'd2, 32'd92);
    do_reset();
    rd_chk("mid_rst_ctrl",   2'd0, 32'h0);
    rd_chk("mid_rst_preset", 2'd1, PR);
    rd_chk("mid_rst_cnt",    2'd2, 32'h0);
    irq_chk("mid_rst_irq", 1'b0);
    for (int k = 0; k < 4; k++) tick();
    rd_chk("mid_rst_idle_cnt", 2'd2, 32'h0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
